// File: rtl/dw_lp_cntr_updn_range.sv
// dw_lp_cntr_updn_range: up/down counter with programmable step, count window
// [min_val, max_val] and wrap / saturate / one-shot limit handling.
// Optional limit-event counter enabled by defining DW_CNTR_EVT_CNT_EN.
module dw_lp_cntr_updn_range #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              up_dn,
  input  logic              ld_n,
  input  logic [WIDTH-1:0]  ld_count,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  min_val,
  input  logic [WIDTH-1:0]  max_val,
  input  logic [WIDTH-1:0]  term_val,
  input  logic [1:0]        mode,
  output logic [WIDTH-1:0]  count,
  output logic              term_count_n,
  output logic              limit,
  output logic              done,
  output logic              cfg_err,
  output logic [WIDTH-1:0]  evt_count
);

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_count, w_count_nxt;
  logic             r_limit, w_limit_nxt;

  logic [WIDTH-1:0] w_step;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_min_plus_step;
  logic [WIDTH-1:0] w_diff;
  logic             w_out_rng;
  logic             w_ovf;
  logic             w_unf;
  logic             w_sat_mode;
  logic             w_oneshot;
  logic             w_hit_term;
  logic             w_frozen;

  // Step arithmetic and limit detection; sums carry one extra bit so the
  // bound compares cannot alias on overflow.
  always_comb begin
    w_step          = WIDTH'(step);
    w_sum           = {1'b0, r_count} + {1'b0, w_step};
    w_min_plus_step = {1'b0, min_val} + {1'b0, w_step};
    w_diff          = r_count - w_step;
    w_out_rng       = (r_count < min_val) || (r_count > max_val);
    w_ovf           = w_out_rng || (w_sum > {1'b0, max_val});
    w_unf           = w_out_rng || ({1'b0, r_count} < w_min_plus_step);
    w_sat_mode      = (mode == 2'b01) || (mode == 2'b10);
    w_oneshot       = (mode == 2'b10);
    w_hit_term      = (r_state == RUN) && w_oneshot && (r_count == term_val);
    w_frozen        = !enable || (step == '0) || cfg_err || (r_state == DONE);
  end

  // Next-state / next-count selection: load > one-shot terminal > count > hold.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_limit_nxt = 1'b0;
    if (!ld_n) begin
      w_state_nxt = RUN;
      w_count_nxt = ld_count;
    end else if (w_hit_term) begin
      w_state_nxt = DONE;
    end else if (!w_frozen) begin
      if (up_dn) begin
        if (w_ovf) begin
          w_count_nxt = w_sat_mode ? max_val : min_val;
          w_limit_nxt = 1'b1;
        end else begin
          w_count_nxt = w_sum[WIDTH-1:0];
        end
      end else begin
        if (w_unf) begin
          w_count_nxt = w_sat_mode ? min_val : max_val;
          w_limit_nxt = 1'b1;
        end else begin
          w_count_nxt = w_diff;
        end
      end
    end
  end

  // State, count and limit-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_count <= '0;
      r_limit <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_limit <= w_limit_nxt;
    end
  end

`ifdef DW_CNTR_EVT_CNT_EN
  logic [WIDTH-1:0] r_evt;

  // Count limit events; load and reset clear the tally.
  always_ff @(posedge clk) begin
    if (rst || !ld_n) begin
      r_evt <= '0;
    end else if (w_limit_nxt) begin
      r_evt <= r_evt + 1'b1;
    end
  end

  assign evt_count = r_evt;
`else
  assign evt_count = '0;
`endif

  assign count        = r_count;
  assign limit        = r_limit;
  assign done         = (r_state == DONE);
  assign cfg_err      = (min_val > max_val);
  assign term_count_n = !(r_count == term_val);

endmodule

// File: tb/tb_dw_lp_cntr_updn_range.sv
// Self-checking bench for dw_lp_cntr_updn_range: directed vector table
// followed by randomized stimulus against a behavioural reference model.
module tb_dw_lp_cntr_updn_range;

  localparam int WIDTH  = 8;
  localparam int STEP_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic              up_dn = 1'b1;
  logic              ld_n = 1'b1;
  logic [WIDTH-1:0]  ld_count = '0;
  logic [STEP_W-1:0] step = '0;
  logic [WIDTH-1:0]  min_val = '0;
  logic [WIDTH-1:0]  max_val = '1;
  logic [WIDTH-1:0]  term_val = '0;
  logic [1:0]        mode = '0;
  logic [WIDTH-1:0]  count;
  logic              term_count_n;
  logic              limit;
  logic              done;
  logic              cfg_err;
  logic [WIDTH-1:0]  evt_count;

  dw_lp_cntr_updn_range #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .up_dn(up_dn), .ld_n(ld_n),
    .ld_count(ld_count), .step(step), .min_val(min_val), .max_val(max_val),
    .term_val(term_val), .mode(mode), .count(count), .term_count_n(term_count_n),
    .limit(limit), .done(done), .cfg_err(cfg_err), .evt_count(evt_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (plain integers).
  int m_count = 0;
  int m_done  = 0;
  int m_limit = 0;
  int m_evt   = 0;

  typedef struct {
    int rst; int ld_n; int ld; int en; int up; int stp;
    int mn; int mx; int term; int mode;
    int e_cnt; int e_lim; int e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int r, int l, int ld, int en, int up, int s,
                              int mn, int mx, int tm, int md,
                              int ec, int el, int ed);
    vec_t v;
    v.rst = r; v.ld_n = l; v.ld = ld; v.en = en; v.up = up; v.stp = s;
    v.mn = mn; v.mx = mx; v.term = tm; v.mode = md;
    v.e_cnt = ec; v.e_lim = el; v.e_done = ed;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock edge of the behaviour as described: rst > load > one-shot
  // terminal hit > counting (unless frozen) > hold.
  task automatic model_edge();
    int c, lo, hi, s;
    bit sat, ev;
    c = m_count; lo = int'(min_val); hi = int'(max_val); s = int'(step);
    sat = (mode == 2'd1) || (mode == 2'd2);
    ev  = 1'b0;
    if (rst) begin
      m_count = 0; m_done = 0; m_limit = 0; m_evt = 0;
    end else if (!ld_n) begin
      m_count = int'(ld_count); m_done = 0; m_limit = 0; m_evt = 0;
    end else if (m_done == 0 && mode == 2'd2 && c == int'(term_val)) begin
      m_done = 1; m_limit = 0;
    end else if (!enable || s == 0 || lo > hi || m_done != 0) begin
      m_limit = 0;
    end else begin
      if (up_dn) begin
        if (c < lo || c > hi || c + s > hi) begin
          m_count = sat ? hi : lo; ev = 1'b1;
        end else m_count = c + s;
      end else begin
        if (c < lo || c > hi || c - s < lo) begin
          m_count = sat ? lo : hi; ev = 1'b1;
        end else m_count = c - s;
      end
      m_limit = ev ? 1 : 0;
`ifdef DW_CNTR_EVT_CNT_EN
      if (ev) m_evt = (m_evt + 1) % (1 << WIDTH);
`endif
    end
  endtask

  // Advance one edge and compare every output against the model.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("count", int'(count), m_count);
    chk("limit", int'(limit), m_limit);
    chk("done", int'(done), m_done);
    chk("evt_count", int'(evt_count), m_evt);
    chk("term_count_n", int'(term_count_n), (m_count == int'(term_val)) ? 0 : 1);
    chk("cfg_err", int'(cfg_err), (min_val > max_val) ? 1 : 0);
  endtask

  initial begin
    // Reset / load
    add(1,1,0,0,1,1, 0,15,200,0, 0,0,0);
    add(0,0,5,0,1,1, 0,15,200,0, 5,0,0);
    add(1,0,7,0,1,1, 0,15,200,0, 0,0,0);
    // Wrap up, step 3, window [2,10]
    add(0,0,8,1,1,3, 2,10,200,0, 8,0,0);
    add(0,1,0,1,1,3, 2,10,200,0, 2,1,0);
    add(0,1,0,1,1,3, 2,10,200,0, 5,0,0);
    add(0,1,0,1,1,3, 2,10,200,0, 8,0,0);
    add(0,1,0,1,1,3, 2,10,200,0, 2,1,0);
    // Saturate down, step 4, window [3,12]
    add(0,0,9,1,0,4, 3,12,200,1, 9,0,0);
    add(0,1,0,1,0,4, 3,12,200,1, 5,0,0);
    add(0,1,0,1,0,4, 3,12,200,1, 3,1,0);
    add(0,1,0,1,0,4, 3,12,200,1, 3,1,0);
    add(0,1,0,1,0,4, 3,12,200,1, 3,1,0);
    // Saturate up at max, repeated attempt (mode 3 check later)
    add(0,0,12,1,1,2, 3,12,200,1, 12,0,0);
    add(0,1,0,1,1,2, 3,12,200,1, 12,1,0);
    // One-shot up to term 4
    add(0,0,0,1,1,1, 0,15,4,2, 0,0,0);
    for (int i = 1; i <= 4; i++) add(0,1,0,1,1,1, 0,15,4,2, i,0,0);
    add(0,1,0,1,1,1, 0,15,4,2, 4,0,1);
    add(0,1,0,1,1,1, 0,15,4,2, 4,0,1);
    add(0,1,0,1,1,1, 0,15,4,0, 4,0,1);
    add(0,0,1,1,1,1, 0,15,4,2, 1,0,0);
    // Freeze: step 0, enable 0, cfg_err
    add(0,0,6,1,1,0, 0,15,200,0, 6,0,0);
    for (int i = 0; i < 5; i++) add(0,1,0,1,1,0, 0,15,200,0, 6,0,0);
    for (int i = 0; i < 5; i++) add(0,1,0,0,1,1, 0,15,200,0, 6,0,0);
    for (int i = 0; i < 5; i++) add(0,1,0,1,1,1, 9,3,200,0, 6,0,0);
    // Out-of-range load, wrap via mode 3
    add(0,0,12,1,1,1, 4,8,200,3, 12,0,0);
    add(0,1,0,1,1,1, 4,8,200,3, 4,1,0);
    for (int i = 5; i <= 8; i++) add(0,1,0,1,1,1, 4,8,200,3, i,0,0);
    // Load coincident with overflow: load wins, no limit
    add(0,0,3,1,1,1, 4,8,200,3, 3,0,0);
    // Reset mid-count overrides load
    add(0,1,0,1,1,1, 4,8,200,0, 4,1,0);
    add(1,0,9,1,1,1, 4,8,200,0, 0,0,0);

    #2;
    foreach (vecs[i]) begin
      rst      = vecs[i].rst[0];
      ld_n     = vecs[i].ld_n[0];
      ld_count = WIDTH'(vecs[i].ld);
      enable   = vecs[i].en[0];
      up_dn    = vecs[i].up[0];
      step     = STEP_W'(vecs[i].stp);
      min_val  = WIDTH'(vecs[i].mn);
      max_val  = WIDTH'(vecs[i].mx);
      term_val = WIDTH'(vecs[i].term);
      mode     = 2'(vecs[i].mode);
      tick();
      chk("vec_count", int'(count), vecs[i].e_cnt);
      chk("vec_limit", int'(limit), vecs[i].e_lim);
      chk("vec_done", int'(done), vecs[i].e_done);
      chk("vec_tcn", int'(term_count_n), (vecs[i].e_cnt == vecs[i].term) ? 0 : 1);
      chk("vec_cfg_err", int'(cfg_err), (vecs[i].mn > vecs[i].mx) ? 1 : 0);
    end

    // Randomized stimulus against the reference model.
    min_val = 8'd10; max_val = 8'd60; term_val = 8'd30;
    for (int n = 0; n < 3000; n++) begin
      rst    = ($urandom_range(0, 99) == 0);
      ld_n   = !($urandom_range(0, 15) == 0);
      ld_count = WIDTH'($urandom_range(0, 255));
      enable = ($urandom_range(0, 3) != 0);
      up_dn  = $urandom_range(0, 1) != 0;
      step   = STEP_W'($urandom_range(0, 15));
      mode   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) begin
        min_val = WIDTH'($urandom_range(0, 120));
        max_val = WIDTH'($urandom_range(60, 255));
      end
      if ($urandom_range(0, 15) == 0) term_val = WIDTH'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) term_val = WIDTH'(m_count);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dw_lp_cntr_updn_range.md
# dw_lp_cntr_updn_range

Parametrised up/down counter with programmable step, programmable count window [min_val, max_val], and three limit modes: wrap, saturate, and one-shot. It is the next generation of the low-power up/down counter with load, enable and terminal-count compare, and it is used for timers, address sequencers and credit counters. It adds a step size, range bounds, an optional limit-event counter, and a one-shot done state.

## Interface
- WIDTH, 8, counter and bound width (≥2)
- STEP_W, 4, step input width (STEP_W ≤ WIDTH)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- enable  in  1  count enable
- up_dn  in  1  1 = count up, 0 = count down
- ld_n  in  1  active-low synchronous load
- ld_count  in  WIDTH  load value
- step  in  STEP_W  increment/decrement magnitude, unsigned
- min_val  in  WIDTH  lower bound, unsigned
- max_val  in  WIDTH  upper bound, unsigned
- term_val  in  WIDTH  terminal compare value
- mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
- count  out  WIDTH  registered count
- term_count_n  out  1  low while count == term_val (combinational from count)
- limit  out  1  registered one-cycle pulse on a wrap or saturation event
- done  out  1  high while in DONE state (one-shot mode)
- cfg_err  out  1  combinational; high when min_val > max_val
- evt_count  out  WIDTH  number of limit events (see Configuration)

## Operation
- Priority: rst > load (ld_n=0) > count (enable=1) > hold.
- The FSM has two states: RUN and DONE. Reset and load both go to RUN.
- Load: count ← ld_count as-is, with no range check. A load also clears done and limit.
- Counting is frozen (count held, limit=0) in any of these cases: enable=0, step=0, cfg_err=1, or state DONE.
- Next value: nxt = count ± step, computed in WIDTH+1 bits. The result is an overflow if nxt > max_val (up) or an underflow if count < min_val + step (down, underflow-safe compare).
- If count is already outside [min_val, max_val] when a count step occurs, treat it as an overflow (up) or underflow (down).
- Wrap mode (00/11): overflow → count ← min_val; underflow → count ← max_val; limit=1 next cycle.
- Saturate mode (01): overflow → count ← max_val; underflow → count ← min_val; limit=1 on every such cycle, including repeated attempts while already at the bound.
- One-shot mode (10): counting follows saturate rules. When the registered count equals term_val in RUN, the FSM moves to DONE on the next edge and done=1.
- DONE is left only by load or reset. A mode change while in DONE does not exit DONE.
- Changes to mode, min_val, max_val and step take effect on the next counting edge. No restart is needed.

## Timing
- Reset values: count=0, term_count_n = !(term_val==0), limit=0, done=0, evt_count=0, state RUN.
- Latency from load or count to count output: one edge.
- term_count_n follows count in zero cycles (combinational compare).
- limit is registered. It is high in the cycle where count shows the wrapped or saturated value.
- done rises one edge after count==term_val in one-shot mode. count does not advance on that edge.
- rst asserted mid-count takes effect on that edge and overrides a simultaneous load.
- Load coincident with an overflow: the load wins and limit=0.

## Configuration
- `DW_CNTR_EVT_CNT_EN` defined: evt_count increments (wrapping modulo 2^WIDTH) on each edge where limit is being set. It is cleared by reset and load.
- `DW_CNTR_EVT_CNT_EN` undefined: evt_count is tied to 0, and no event-counter flops are generated.

## Test plan
- Reset/load: rst=1 for 1 edge → count=0, done=0. Then ld_n=0 with ld_count=5 → count=5 next edge. ld_n=0 with rst=1 → count=0.
- Wrap up, step 3: min=2, max=10, ld 8, up → counting sequence 8, 2, 5, 8, 2. limit pulses with each 2. With the macro defined, evt_count=2 after the second wrap.
- Saturate down, step 4: min=3, max=12, ld 9, dn → 9, 5, 3, 3, 3. limit stays high from the first 3 onward.
- One-shot up, step 1: min=0, max=15, term=4, ld 0 → 0..4. term_count_n=0 at 4, done=1 next edge, count holds at 4 with enable=1. Then ld 1 → RUN, done=0.
- Freeze conditions: step=0, enable=0, or min=9/max=3 (cfg_err=1) → count unchanged for 5 edges and limit=0.
- Out-of-range load: min=4, max=8, ld 12, up, wrap → next count=4 and limit=1.
